// File: rtl/stack_cpu_ctrl.sv
// Multi-cycle control unit for the 16-bit stack CPU: fetch, decode, stack pops/pushes, load/store, jump.
// Optional macro STACK_CHECK_EN traps a POP on an empty stack into ERROR.
module stack_cpu_ctrl #(
  parameter int unsigned ILLEGAL_HALTS = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       sr_empty,
  output logic       cmd_w,
  output logic       R1_w,
  output logic       R2_w,
  output logic       SR_w,
  output logic       PC_w,
  output logic       SR_inc,
  output logic       PC_inc,
  output logic [1:0] SR_incc,
  output logic [1:0] PC_incc,
  output logic [2:0] ALU_func,
  output logic [1:0] addr_sel,
  output logic [1:0] data_sel,
  output logic       write_memory,
  output logic       error,
  output logic       halted,
  output logic [3:0] state
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_POP_R2  = 4'd3,
    S_POP_R1  = 4'd4,
    S_LIT_RD  = 4'd5,
    S_PUSH    = 4'd6,
    S_LD_RD   = 4'd7,
    S_ST_WR   = 4'd8,
    S_JMP_SET = 4'd9,
    S_HALT    = 4'd10,
    S_ERROR   = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_NOP  = 6'h00;
  localparam logic [OP_W-1:0] OP_LIT  = 6'h01;
  localparam logic [OP_W-1:0] OP_ADD  = 6'h02;
  localparam logic [OP_W-1:0] OP_XOR  = 6'h06;
  localparam logic [OP_W-1:0] OP_LD   = 6'h08;
  localparam logic [OP_W-1:0] OP_ST   = 6'h09;
  localparam logic [OP_W-1:0] OP_JMP  = 6'h0A;
  localparam logic [OP_W-1:0] OP_HALT = 6'h3F;

  localparam logic [2:0] ALU_PASS_R1 = 3'd0;
  localparam logic [2:0] ALU_PASS_R2 = 3'd6;

  localparam logic [1:0] NXT_ALU   = 2'd0;
  localparam logic [1:0] NXT_STEP  = 2'd1;
  localparam logic [1:0] NXT_CONST = 2'd2;

  localparam logic [1:0] ADDR_SR    = 2'd0;
  localparam logic [1:0] ADDR_SR_ID = 2'd1;
  localparam logic [1:0] ADDR_PC    = 2'd2;
  localparam logic [1:0] ADDR_R1    = 2'd3;

  localparam logic [1:0] DATA_ALU = 2'd2;

  typedef struct packed {
    logic       cmd_w;
    logic       r1_w;
    logic       r2_w;
    logic       sr_w;
    logic       pc_w;
    logic       sr_inc;
    logic       pc_inc;
    logic [1:0] sr_incc;
    logic [1:0] pc_incc;
    logic [2:0] alu_func;
    logic [1:0] addr_sel;
    logic [1:0] data_sel;
    logic       write_memory;
    logic       halted;
    logic       error;
  } ctrl_t;

  state_t state_q;
  ctrl_t  ctrl_q;
  logic   underflow;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  // Instruction sequencing; each multi-step opcode walks its own fixed path.
  function automatic state_t next_state(input state_t cur, input logic [OP_W-1:0] op);
    state_t nxt;
    nxt = S_ERROR;
    case (cur)
      S_INIT:   nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (op == OP_NOP)                          nxt = S_FETCH;
        else if (op == OP_LIT)                     nxt = S_LIT_RD;
        else if (is_alu_op(op))                    nxt = S_POP_R2;
        else if (op == OP_LD || op == OP_ST ||
                 op == OP_JMP)                     nxt = S_POP_R1;
        else if (op == OP_HALT)                    nxt = S_HALT;
        else if (ILLEGAL_HALTS != 0)               nxt = S_HALT;
        else                                       nxt = S_ERROR;
      end
      S_POP_R2: begin
        if (is_alu_op(op))      nxt = S_POP_R1;
        else if (op == OP_ST)   nxt = S_ST_WR;
        else                    nxt = S_ERROR;
      end
      S_POP_R1: begin
        if (is_alu_op(op))      nxt = S_PUSH;
        else if (op == OP_LD)   nxt = S_LD_RD;
        else if (op == OP_ST)   nxt = S_POP_R2;
        else if (op == OP_JMP)  nxt = S_JMP_SET;
        else                    nxt = S_ERROR;
      end
      S_LIT_RD:  nxt = S_PUSH;
      S_PUSH:    nxt = S_FETCH;
      S_LD_RD:   nxt = S_PUSH;
      S_ST_WR:   nxt = S_FETCH;
      S_JMP_SET: nxt = S_FETCH;
      S_HALT:    nxt = S_HALT;
      default:   nxt = S_ERROR;
    endcase
    return nxt;
  endfunction

  // Moore control word for a state; only PUSH looks at the opcode.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_INIT: begin
        c.sr_w    = 1'b1;
        c.pc_w    = 1'b1;
        c.sr_incc = NXT_CONST;
        c.pc_incc = NXT_CONST;
      end
      S_FETCH: begin
        c.addr_sel = ADDR_PC;
        c.cmd_w    = 1'b1;
        c.pc_w     = 1'b1;
        c.pc_incc  = NXT_STEP;
        c.pc_inc   = 1'b1;
      end
      S_POP_R2, S_POP_R1: begin
        c.addr_sel = ADDR_SR;
        c.r2_w     = (s == S_POP_R2);
        c.r1_w     = (s == S_POP_R1);
        c.sr_w     = 1'b1;
        c.sr_incc  = NXT_STEP;
        c.sr_inc   = 1'b1;
      end
      S_LIT_RD: begin
        c.addr_sel = ADDR_PC;
        c.r1_w     = 1'b1;
        c.pc_w     = 1'b1;
        c.pc_incc  = NXT_STEP;
        c.pc_inc   = 1'b1;
      end
      S_PUSH: begin
        c.sr_inc       = 1'b0;
        c.addr_sel     = ADDR_SR_ID;
        c.data_sel     = DATA_ALU;
        c.write_memory = 1'b1;
        c.sr_w         = 1'b1;
        c.sr_incc      = NXT_STEP;
        if (op == OP_LD)        c.alu_func = ALU_PASS_R2;
        else if (is_alu_op(op)) c.alu_func = 3'(op - 6'd1);
        else                    c.alu_func = ALU_PASS_R1;
      end
      S_LD_RD: begin
        c.addr_sel = ADDR_R1;
        c.r2_w     = 1'b1;
      end
      S_ST_WR: begin
        c.addr_sel     = ADDR_R1;
        c.data_sel     = DATA_ALU;
        c.alu_func     = ALU_PASS_R2;
        c.write_memory = 1'b1;
      end
      S_JMP_SET: begin
        c.pc_w     = 1'b1;
        c.pc_incc  = NXT_ALU;
        c.alu_func = ALU_PASS_R1;
      end
      S_HALT:  c.halted = 1'b1;
      S_ERROR: c.error  = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

`ifdef STACK_CHECK_EN
  assign underflow = sr_empty && ((state_q == S_POP_R1) || (state_q == S_POP_R2));
`else
  logic unused_sr_empty;
  assign unused_sr_empty = sr_empty;
  assign underflow       = 1'b0;
`endif

  // State and control word advance together so every output leaves a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ctrl_q  <= decode_ctrl(S_INIT, opcode);
    end else if (underflow) begin
      state_q <= S_ERROR;
      ctrl_q  <= decode_ctrl(S_ERROR, opcode);
    end else begin
      state_q <= next_state(state_q, opcode);
      ctrl_q  <= decode_ctrl(next_state(state_q, opcode), opcode);
    end
  end

  // An underflowing POP must not disturb any register or memory.
  assign cmd_w        = ctrl_q.cmd_w        & ~underflow;
  assign R1_w         = ctrl_q.r1_w         & ~underflow;
  assign R2_w         = ctrl_q.r2_w         & ~underflow;
  assign SR_w         = ctrl_q.sr_w         & ~underflow;
  assign PC_w         = ctrl_q.pc_w         & ~underflow;
  assign write_memory = ctrl_q.write_memory & ~underflow;
  assign SR_inc       = ctrl_q.sr_inc;
  assign PC_inc       = ctrl_q.pc_inc;
  assign SR_incc      = ctrl_q.sr_incc;
  assign PC_incc      = ctrl_q.pc_incc;
  assign ALU_func     = ctrl_q.alu_func;
  assign addr_sel     = ctrl_q.addr_sel;
  assign data_sel     = ctrl_q.data_sel;
  assign halted       = ctrl_q.halted;
  assign error        = ctrl_q.error;
  assign state        = state_q;

endmodule

// File: tb/tb_stack_cpu_ctrl.sv
// Bench for stack_cpu_ctrl: a small datapath/memory model runs programs under the controller.
module tb_stack_cpu_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       sr_empty;
  logic       cmd_w, R1_w, R2_w, SR_w, PC_w, SR_inc, PC_inc;
  logic [1:0] SR_incc, PC_incc, addr_sel, data_sel;
  logic [2:0] ALU_func;
  logic       write_memory, error, halted;
  logic [3:0] state;

  stack_cpu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .sr_empty(sr_empty),
    .cmd_w(cmd_w), .R1_w(R1_w), .R2_w(R2_w), .SR_w(SR_w), .PC_w(PC_w),
    .SR_inc(SR_inc), .PC_inc(PC_inc), .SR_incc(SR_incc), .PC_incc(PC_incc),
    .ALU_func(ALU_func), .addr_sel(addr_sel), .data_sel(data_sel),
    .write_memory(write_memory), .error(error), .halted(halted), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       cmd_w, r1_w, r2_w, sr_w, pc_w, sr_inc, pc_inc;
    logic [1:0] sr_incc, pc_incc;
    logic [2:0] alu_func;
    logic [1:0] addr_sel, data_sel;
    logic       write_memory, halted, error;
  } ctl_t;

  typedef struct {
    logic [5:0]  op;
    logic [15:0] a, b;
    int          cycles;
    int          nwr;
    logic [15:0] waddr, wdata;
    logic [2:0]  func;
    logic [15:0] next_pc;
  } vec_t;

  localparam int NVEC = 11;

  logic [15:0] mem [0:65535];
  logic [15:0] m_cmd, m_r1, m_r2, m_sr, m_pc;
  logic [15:0] wa[$], wd[$];
  logic [1:0]  ws[$];
  logic [2:0]  wf[$];
  int          wc[$];
  int          fcyc[32];
  logic [15:0] faddr[32];
  int          nf, cyc;
  int          checks, errors;
  vec_t        vecs[NVEC];

  assign opcode   = m_cmd[15:10];
  assign sr_empty = (m_sr == 16'hFFFF);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Hand-written control word for each state (PUSH ALU function checked per instruction).
  function automatic ctl_t exp_ctl(input logic [3:0] s);
    ctl_t c;
    c = '0;
    case (s)
      4'd0:  begin c.sr_w = 1; c.pc_w = 1; c.sr_incc = 2; c.pc_incc = 2; end
      4'd1:  begin c.addr_sel = 2; c.cmd_w = 1; c.pc_w = 1; c.pc_incc = 1; c.pc_inc = 1; end
      4'd3:  begin c.r2_w = 1; c.sr_w = 1; c.sr_incc = 1; c.sr_inc = 1; end
      4'd4:  begin c.r1_w = 1; c.sr_w = 1; c.sr_incc = 1; c.sr_inc = 1; end
      4'd5:  begin c.addr_sel = 2; c.r1_w = 1; c.pc_w = 1; c.pc_incc = 1; c.pc_inc = 1; end
      4'd6:  begin c.addr_sel = 1; c.data_sel = 2; c.write_memory = 1; c.sr_w = 1; c.sr_incc = 1; end
      4'd7:  begin c.addr_sel = 3; c.r2_w = 1; end
      4'd8:  begin c.addr_sel = 3; c.data_sel = 2; c.alu_func = 6; c.write_memory = 1; end
      4'd9:  begin c.pc_w = 1; end
      4'd10: c.halted = 1;
      4'd11: c.error = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // One clock: check the control word at the negedge, then apply it to the datapath model.
  task automatic tick();
    ctl_t act, exp;
    logic [15:0] sr_id, pc_id, a, rd, alu, d, n_sr, n_pc;
    @(negedge clk);
    cyc++;
    act = {cmd_w, R1_w, R2_w, SR_w, PC_w, SR_inc, PC_inc, SR_incc, PC_incc,
           ALU_func, addr_sel, data_sel, write_memory, halted, error};
    exp = exp_ctl(state);
`ifdef STACK_CHECK_EN
    if ((state == 4'd3 || state == 4'd4) && sr_empty) begin
      exp.r1_w = 0; exp.r2_w = 0; exp.sr_w = 0;
    end
`endif
    if (state == 4'd6) act.alu_func = 3'd0;
    chk($sformatf("ctl_state%0d", state), 32'(act), 32'(exp));
    if (state == 4'd1 && nf < 32) begin
      fcyc[nf] = cyc; faddr[nf] = m_pc; nf++;
    end
    sr_id = SR_inc ? m_sr + 16'd1 : m_sr - 16'd1;
    pc_id = PC_inc ? m_pc + 16'd1 : m_pc - 16'd1;
    case (addr_sel)
      2'd0: a = m_sr;
      2'd1: a = sr_id;
      2'd2: a = m_pc;
      default: a = m_r1;
    endcase
    rd = mem[a];
    case (ALU_func)
      3'd0: alu = m_r1;
      3'd1: alu = m_r1 + m_r2;
      3'd2: alu = m_r1 - m_r2;
      3'd3: alu = m_r1 & m_r2;
      3'd4: alu = m_r1 | m_r2;
      3'd5: alu = m_r1 ^ m_r2;
      3'd6: alu = m_r2;
      default: alu = 16'h0000;
    endcase
    case (data_sel)
      2'd0: d = m_sr;
      2'd1: d = pc_id;
      2'd2: d = alu;
      default: d = m_cmd;
    endcase
    case (SR_incc)
      2'd0: n_sr = alu;
      2'd1: n_sr = sr_id;
      2'd2: n_sr = 16'hFFFF;
      default: n_sr = 16'h0000;
    endcase
    case (PC_incc)
      2'd0: n_pc = alu;
      2'd1: n_pc = pc_id;
      2'd2: n_pc = 16'h0020;
      default: n_pc = 16'h0000;
    endcase
    if (write_memory === 1'b1) begin
      mem[a] = d;
      wa.push_back(a); wd.push_back(d); ws.push_back(addr_sel);
      wf.push_back(ALU_func); wc.push_back(cyc);
    end
    if (cmd_w === 1'b1) m_cmd = rd;
    if (R1_w === 1'b1)  m_r1 = rd;
    if (R2_w === 1'b1)  m_r2 = rd;
    if (SR_w === 1'b1)  m_sr = n_sr;
    if (PC_w === 1'b1)  m_pc = n_pc;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wa.delete(); wd.delete(); ws.delete(); wf.delete(); wc.delete();
    nf = 0;
    tick();
    tick();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_error", 32'(error), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic run_until_stop(input int budget);
    int n;
    n = 0;
    while (!(halted === 1'b1 || error === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    chk("run_within_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int nw, wi;
    checks = 0; errors = 0; cyc = 0; nf = 0;
    rst_n = 1'b0;

    //                op     a         b         cyc wr waddr     wdata     func  next_pc
    vecs[0]  = '{6'h02, 16'h1111, 16'h2222, 5, 1, 16'hFFFE, 16'h3333, 3'd1, 16'h0025};
    vecs[1]  = '{6'h03, 16'h0001, 16'h0002, 5, 1, 16'hFFFE, 16'hFFFF, 3'd2, 16'h0025};
    vecs[2]  = '{6'h04, 16'hF0F0, 16'h3C3C, 5, 1, 16'hFFFE, 16'h3030, 3'd3, 16'h0025};
    vecs[3]  = '{6'h05, 16'hF0F0, 16'h0F00, 5, 1, 16'hFFFE, 16'hFFF0, 3'd4, 16'h0025};
    vecs[4]  = '{6'h06, 16'hFFFF, 16'h1234, 5, 1, 16'hFFFE, 16'hEDCB, 3'd5, 16'h0025};
    vecs[5]  = '{6'h02, 16'hFFFF, 16'h0002, 5, 1, 16'hFFFE, 16'h0001, 3'd1, 16'h0025};
    vecs[6]  = '{6'h00, 16'h0000, 16'h0000, 2, 0, 16'h0000, 16'h0000, 3'd0, 16'h0025};
    vecs[7]  = '{6'h08, 16'h5555, 16'h0080, 5, 1, 16'hFFFD, 16'hABCD, 3'd6, 16'h0025};
    vecs[8]  = '{6'h09, 16'h5A5A, 16'h0090, 5, 1, 16'h0090, 16'h5A5A, 3'd6, 16'h0025};
    vecs[9]  = '{6'h0A, 16'h0000, 16'h0050, 4, 0, 16'h0000, 16'h0000, 3'd0, 16'h0050};
    vecs[10] = '{6'h01, 16'h0003, 16'h0004, 4, 1, 16'hFFFC, 16'hFC00, 3'd0, 16'h0026};

    // Reset then LIT 5, LIT 7, ADD, HALT
    clear_mem();
    mem[16'h0020] = 16'h0401; mem[16'h0021] = 16'h0005;
    mem[16'h0022] = 16'h0401; mem[16'h0023] = 16'h0007;
    mem[16'h0024] = 16'h0800; mem[16'h0025] = 16'hFC00;
    do_reset();
    tick();
    chk("post_reset_fetch_state", 32'(state), 32'd1);
    chk("post_reset_fetch_addr_sel", 32'(addr_sel), 32'd2);
    run_until_stop(60);
    chk("add_prog_writes", 32'(wa.size()), 32'd3);
    if (wa.size() == 3) begin
      chk("add_w0", {wa[0], wd[0]}, 32'hFFFE_0005);
      chk("add_w1", {wa[1], wd[1]}, 32'hFFFD_0007);
      chk("add_w2", {wa[2], wd[2]}, 32'hFFFE_000C);
    end
    chk("add_prog_sr", 32'(m_sr), 32'h0000_FFFE);
    chk("add_prog_halted", 32'(halted), 32'd1);

    // SUB: 9 - 3
    clear_mem();
    mem[16'h0020] = 16'h0401; mem[16'h0021] = 16'h0009;
    mem[16'h0022] = 16'h0401; mem[16'h0023] = 16'h0003;
    mem[16'h0024] = 16'h0C00; mem[16'h0025] = 16'hFC00;
    do_reset();
    run_until_stop(60);
    chk("sub_r1", 32'(m_r1), 32'h0009);
    chk("sub_r2", 32'(m_r2), 32'h0003);
    if (wa.size() == 3) begin
      chk("sub_push_func", 32'(wf[2]), 32'd2);
      chk("sub_push", {wa[2], wd[2]}, 32'hFFFE_0006);
    end else chk("sub_prog_writes", 32'(wa.size()), 32'd3);

    // ST then LD through address 0100
    clear_mem();
    mem[16'h0020] = 16'h0401; mem[16'h0021] = 16'h1234;
    mem[16'h0022] = 16'h0401; mem[16'h0023] = 16'h0100;
    mem[16'h0024] = 16'h2400;
    mem[16'h0025] = 16'h0401; mem[16'h0026] = 16'h0100;
    mem[16'h0027] = 16'h2000; mem[16'h0028] = 16'hFC00;
    do_reset();
    run_until_stop(80);
    chk("stld_writes", 32'(wa.size()), 32'd5);
    if (wa.size() == 5) begin
      chk("st_write", {wa[2], wd[2]}, 32'h0100_1234);
      chk("st_addr_sel", 32'(ws[2]), 32'd3);
      chk("ld_push", {wa[4], wd[4]}, 32'hFFFE_1234);
    end

    // LIT 0040, JMP; HALT at 0040 must hold
    clear_mem();
    mem[16'h0020] = 16'h0401; mem[16'h0021] = 16'h0040;
    mem[16'h0022] = 16'h2800; mem[16'h0040] = 16'hFC00;
    do_reset();
    run_until_stop(60);
    chk("jmp_fetch_addr", 32'(nf >= 3 ? faddr[2] : 16'hDEAD), 32'h0040);
    repeat (4) tick();
    chk("halt_hold_state", 32'(state), 32'd10);
    chk("halt_hold_flag", 32'(halted), 32'd1);
    chk("halt_no_error", 32'(error), 32'd0);

    // Illegal opcode 0x15
    clear_mem();
    mem[16'h0020] = 16'h5400;
    do_reset();
    run_until_stop(30);
    repeat (3) tick();
    chk("illegal_state", 32'(state), 32'd11);
    chk("illegal_error", 32'(error), 32'd1);
    chk("illegal_not_halted", 32'(halted), 32'd0);

    // Reset asserted while in POP_R1
    clear_mem();
    mem[16'h0020] = 16'h0401; mem[16'h0021] = 16'h0001;
    mem[16'h0022] = 16'h0401; mem[16'h0023] = 16'h0002;
    mem[16'h0024] = 16'h0800; mem[16'h0025] = 16'hFC00;
    do_reset();
    begin
      int n;
      n = 0;
      while (state !== 4'd4 && n < 40) begin tick(); n++; end
      chk("reach_pop_r1", 32'(state), 32'd4);
    end
    rst_n = 1'b0;
    tick();
    chk("midreset_state", 32'(state), 32'd0);
    chk("midreset_no_writes", 32'({cmd_w, R1_w, R2_w, write_memory}), 32'd0);
    rst_n = 1'b1;

`ifdef STACK_CHECK_EN
    // ADD on an empty stack
    clear_mem();
    mem[16'h0020] = 16'h0800; mem[16'h0021] = 16'hFC00;
    do_reset();
    run_until_stop(30);
    chk("underflow_state", 32'(state), 32'd11);
    chk("underflow_sr", 32'(m_sr), 32'h0000_FFFF);
    chk("underflow_no_writes", 32'(wa.size()), 32'd0);
`endif

    // Table: LIT a, LIT b, <op>, HALT; measure the op's cycles, writes and next fetch
    for (int i = 0; i < NVEC; i++) begin
      clear_mem();
      mem[16'h0020] = 16'h0401; mem[16'h0021] = vecs[i].a;
      mem[16'h0022] = 16'h0401; mem[16'h0023] = vecs[i].b;
      mem[16'h0024] = {vecs[i].op, 10'd0};
      mem[16'h0025] = 16'hFC00; mem[16'h0026] = 16'hFC00;
      mem[16'h0050] = 16'hFC00; mem[16'h0080] = 16'hABCD;
      do_reset();
      run_until_stop(80);
      chk($sformatf("vec%0d_fetches", i), 32'(nf >= 4), 32'd1);
      if (nf >= 4) begin
        nw = 0; wi = 0;
        foreach (wc[k]) if (wc[k] >= fcyc[2] && wc[k] < fcyc[3]) begin nw++; wi = k; end
        chk($sformatf("vec%0d_cycles", i), 32'(fcyc[3] - fcyc[2]), 32'(vecs[i].cycles));
        chk($sformatf("vec%0d_next_pc", i), 32'(faddr[3]), 32'(vecs[i].next_pc));
        chk($sformatf("vec%0d_nwrites", i), 32'(nw), 32'(vecs[i].nwr));
        if (vecs[i].nwr == 1 && nw == 1) begin
          chk($sformatf("vec%0d_write", i), {wa[wi], wd[wi]}, {vecs[i].waddr, vecs[i].wdata});
          chk($sformatf("vec%0d_func", i), 32'(wf[wi]), 32'(vecs[i].func));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_cpu_ctrl.md
Name: stack_cpu_ctrl

Overview:
Multi-cycle control unit for the 16-bit stack CPU datapath (cmd/R1/R2/SR/PC registers, SR/PC inc-dec units, ALU, addr/data muxes). Sequences fetch, decode, stack pops and pushes, memory load/store and jumps by driving every write-enable, mux select and ALU function. Sits beside the datapath inside the CPU top level. Memory read is combinational: in_data is valid in the same cycle addr is driven.

Parameters:
ILLEGAL_HALTS, 0, 1 = an illegal opcode enters HALT instead of ERROR (error stays 0).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
opcode  input  6  cmd register bits [15:10]
sr_empty  input  1  1 when SR_out == 16'hFFFF (stack empty)
cmd_w, R1_w, R2_w, SR_w, PC_w  output  1 each  register write-enables
SR_inc, PC_inc  output  1 each  inc-dec direction: 1 = +1, 0 = -1
SR_incc, PC_incc  output  2 each  next-value mux: 0 ALU_res, 1 inc-dec, 2 start/entry constant, 3 zero
ALU_func  output  3  0 PASS_R1, 1 ADD, 2 SUB (R1-R2), 3 AND, 4 OR, 5 XOR, 6 PASS_R2, 7 reserved
addr_sel  output  2  0 SR_out, 1 SR_id, 2 PC_out, 3 R1
data_sel  output  2  0 SR_out, 1 PC_id, 2 ALU_res, 3 cmd
write_memory  output  1  memory write strobe
error  output  1  sticky fault flag
halted  output  1  1 in HALT
state  output  4  current state code (debug)

Behaviour:
- All outputs are Moore (functions of state, plus opcode in PUSH). Defaults: all enables 0, incc 0, inc 0, sels 0, ALU_func 0.
- States: INIT=0, FETCH=1, DECODE=2, POP_R2=3, POP_R1=4, LIT_RD=5, PUSH=6, LD_RD=7, ST_WR=8, JMP_SET=9, HALT=10, ERROR=11. Codes 12-15 go to ERROR.
- rst_n low at a clock edge: state <= INIT, error <= 0. This applies in any state, including mid-instruction. Outputs stay defaults while in INIT except as listed.
- INIT: SR_w=PC_w=1, SR_incc=PC_incc=2 (SR=FFFF, PC=0020). Next: FETCH.
- FETCH: addr_sel=2, cmd_w=1, PC_w=1, PC_incc=1, PC_inc=1. Next: DECODE.
- DECODE: no writes. Branch on opcode:
  - NOP 0x00 -> FETCH
  - LIT 0x01 -> LIT_RD -> PUSH -> FETCH
  - ADD/SUB/AND/OR/XOR 0x02-0x06 -> POP_R2 -> POP_R1 -> PUSH -> FETCH
  - LD 0x08 -> POP_R1 -> LD_RD -> PUSH -> FETCH
  - ST 0x09 -> POP_R1 -> POP_R2 -> ST_WR -> FETCH
  - JMP 0x0A -> POP_R1 -> JMP_SET -> FETCH
  - HALT 0x3F -> HALT
  - anything else -> ERROR, or HALT if ILLEGAL_HALTS=1
- POP_Rx: addr_sel=0, Rx_w=1, SR_w=1, SR_incc=1, SR_inc=1. The next state comes from the opcode sequence above.
- LIT_RD: addr_sel=2, R1_w=1, PC_w=1, PC_incc=1, PC_inc=1. The literal is the word following the opcode.
- PUSH: SR_inc=0, addr_sel=1 (SR-1), data_sel=2, write_memory=1, SR_w=1, SR_incc=1. ALU_func is PASS_R1 for LIT, PASS_R2 for LD, and opcode-1 for 0x02-0x06.
- LD_RD: addr_sel=3, R2_w=1.
- ST_WR: addr_sel=3, data_sel=2, ALU_func=6, write_memory=1. Stores the second-from-top at the address on top.
- JMP_SET: PC_w=1, PC_incc=0, ALU_func=0.
- HALT: halted=1; the state holds until reset.
- ERROR: error=1; the state holds until reset.
- Arithmetic wraps modulo 2^16. SR and PC wrap through the inc-dec units.
- Cycle counts including FETCH+DECODE: NOP 2, JMP 4, LIT 4, LD 5, ALU ops 5, ST 5.

Optional Feature:
STACK_CHECK_EN
- Defined: in POP_R1/POP_R2 with sr_empty=1, all enables are forced to 0 and the next state is ERROR (underflow).
- Undefined: sr_empty is ignored and SR wraps FFFF->0000.

Test Plan:
- Reset held 2 cycles then released -> INIT asserts SR_w/PC_w with incc=2, then FETCH with addr_sel=2; error=0 and halted=0 throughout.
- Memory 0020:0401 (LIT), 0021:0005, 0022:0401, 0023:0007, 0024:0800 (ADD) -> writes 0005@FFFE, 0007@FFFD, then 000C@FFFE; SR ends at FFFE.
- SUB with stack 0009 (second), 0003 (top) -> R1=0009, R2=0003, ALU_func=2, PUSH writes 0006.
- LIT 1234, LIT 0100, ST, LIT 0100, LD -> write 1234@0100 with addr_sel=3; LD then pushes 1234.
- LIT 0040, JMP -> PC_w with PC_incc=0 in JMP_SET; the next FETCH reads address 0040. Opcode 0x3F -> halted=1 holds; opcode 0x15 -> error=1.
- rst_n low during POP_R1 -> next state INIT with no register writes that cycle. With STACK_CHECK_EN defined, ADD on an empty stack -> ERROR and SR stays FFFF.
